instr_dispatch: RTL and testbench
=================================

Name: instr_dispatch

Overview:
- Pop side of the instruction queue, fed by the control unit.
- Pops one queue entry at a time and expands its copy_count into individual copies.
- Each copy goes to one of three execution units: arithmetic, RAM/DMA or load/store. Per-copy addresses are base + k*delta.
- Tracks outstanding DMA operations, and on the program-end marker drains them before pulsing program_complete to the host.

Parameters:
- LOG_SUPERSCALAR_WIDTH, 3, log2 of the maximum copies per queue entry; copy_count is LOG_SUPERSCALAR_WIDTH+1 bits.
- LOG_MAX_OUTSTANDING_RAM, 2, log2 of the in-flight DMA limit (4).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- queue_empty  in  1  instruction queue empty; show-ahead data is valid when low
- queue_re  out  1  pop strobe; the entry is consumed on the clock edge
- q_instr_type  in  2  0=LOAD_STORE, 1=RAM, 2=ARITHMETIC, 3=PROG_END
- q_copy_count  in  LOG_SUPERSCALAR_WIDTH+1  number of copies
- q_arith_instr  in  9;  q_ram_instr  in  3;  q_ld_st_instr  in  7
- q_cache_addr, q_main_mem_addr, q_d_cache_addr, q_d_main_mem_addr  in  18 each
- arith_valid  out  1;  arith_ready  in  1;  arith_instr  out  9
- ram_valid  out  1;  ram_ready  in  1;  ram_instr  out  3;  ram_cache_addr, ram_main_mem_addr  out  18
- ram_done  in  1  one-cycle pulse per completed DMA
- ldst_valid  out  1;  ldst_ready  in  1;  ldst_instr  out  7;  ldst_cache_addr  out  18
- program_complete  out  1  one-cycle pulse
- dispatch_error  out  1  sticky error flag
- perf_issued, perf_stall_cycles  out  32 each

Behaviour:
- Reset: all outputs are 0, state is FETCH, outstanding=0, copy_idx=0. Reset mid-transfer drops the latched entry; in-flight ram_done pulses after reset are ignored because the counter saturates at 0.
- States: FETCH, ISSUE, DRAIN.
- FETCH:
  - If !queue_empty: queue_re=1 (combinational), latch all fields, copy_idx=0, cur_cache=q_cache_addr, cur_mm=q_main_mem_addr.
  - Next state: PROG_END -> DRAIN; copy_count==0 -> set dispatch_error, stay in FETCH; otherwise -> ISSUE.
- ISSUE:
  - Assert exactly one valid, selected by the latched type.
  - Address outputs = cur_cache / cur_mm; instruction fields are passed through.
  - On valid&&ready: copy_idx++, cur_cache += d_cache, cur_mm += d_main_mem, all modulo 2^18 with no overflow flag.
- Last copy:
  - The last copy is the handshake with copy_idx==copy_count-1.
  - If the queue is non-empty that cycle, queue_re=1 and the next entry is latched (back-to-back, same rules as FETCH). Otherwise go to FETCH.
  - Sustained throughput: one copy per cycle.
- Valid is held with stable data until ready; a unit may hold ready high.
- RAM flow control:
  - outstanding +1 on a ram handshake, -1 on ram_done; both in one cycle leaves it unchanged.
  - When outstanding==2^LOG_MAX_OUTSTANDING_RAM, ram_valid stays low.
  - ram_done with outstanding==0 sets dispatch_error; the counter stays 0.
- DRAIN: wait for outstanding==0 (it may already be 0), then program_complete=1 for one cycle and go to FETCH.
- Arith and load/store need no draining; their handshake is retirement.
- No queue pops occur while in DRAIN.

Optional Feature:
- DISPATCH_PERF_COUNTERS_EN defined:
  - perf_issued counts copy handshakes.
  - perf_stall_cycles counts ISSUE cycles with valid && !ready, plus cycles where ram_valid is withheld by the outstanding limit.
  - Both are 32-bit, wrapping, reset to 0.
- Undefined: both ports are tied to 0 and no counter flops are instantiated.

Decomposition:
- Shared package cherry_pkg holds:
  - INSTR_TYPE_LOAD_STORE/RAM/ARITHMETIC/PROG_END constants;
  - the address width of 18;
  - instruction field widths (arith 9, ram 3, ld_st 7);
  - the dispatch state enum.
- One sub-module, dispatch_addr_stepper: loads base and delta, then steps on advance, for two 18-bit accumulators.

Test Plan:
- ARITH entry, copy_count=3, arith_ready=1 -> arith_valid on 3 consecutive cycles, queue_re exactly once, then FETCH.
- RAM entry, cache=100, d=5, mm=0x3FFFE, dmm=3, count=3 -> cache 100,105,110; mm 0x3FFFE,0x00001,0x00004.
- Five RAM copies, ram_done never pulsed -> exactly 4 handshakes, then ram_valid low. One ram_done -> the fifth issues.
- LDST entry, count=2, ldst_ready low for 3 cycles -> valid and data stable throughout; with the macro defined, perf_stall_cycles=3.
- RAM entry count=1, then PROG_END; ram_done 10 cycles later -> program_complete pulses exactly one cycle after outstanding reaches 0.
- copy_count=0 entry -> dispatch_error=1, no unit valid, next entry dispatched normally.

Source files
------------

// File: rtl/cherry_pkg.sv
// Shared definitions for the instruction dispatch slice.
//   - instruction type encodings carried on q_instr_type
//   - address and instruction field widths
//   - dispatch FSM state type
package cherry_pkg;

  localparam int unsigned ADDR_W  = 18;
  localparam int unsigned ARITH_W = 9;
  localparam int unsigned RAM_W   = 3;
  localparam int unsigned LDST_W  = 7;

  localparam logic [1:0] INSTR_TYPE_LOAD_STORE = 2'd0;
  localparam logic [1:0] INSTR_TYPE_RAM        = 2'd1;
  localparam logic [1:0] INSTR_TYPE_ARITHMETIC = 2'd2;
  localparam logic [1:0] INSTR_TYPE_PROG_END   = 2'd3;

  typedef enum logic [1:0] {
    DISP_FETCH,
    DISP_ISSUE,
    DISP_DRAIN
  } dispatch_state_e;

endpackage

// File: rtl/dispatch_addr_stepper.sv
// Two independent address accumulators for copy expansion.
// load captures base and delta for both; advance adds the stored delta
// (modulo 2^ADDR_W). load wins if both are asserted in the same cycle.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   load_i, advance_i     capture new base/delta, step by delta
//   base_a_i, delta_a_i   accumulator A (cache address)
//   base_b_i, delta_b_i   accumulator B (main memory address)
//   acc_a_o, acc_b_o      current accumulator values
module dispatch_addr_stepper
  import cherry_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic              advance_i,
  input  logic [ADDR_W-1:0] base_a_i,
  input  logic [ADDR_W-1:0] delta_a_i,
  input  logic [ADDR_W-1:0] base_b_i,
  input  logic [ADDR_W-1:0] delta_b_i,
  output logic [ADDR_W-1:0] acc_a_o,
  output logic [ADDR_W-1:0] acc_b_o
);

  logic [ADDR_W-1:0] acc_a_q, acc_b_q, delta_a_q, delta_b_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_a_q   <= '0;
      acc_b_q   <= '0;
      delta_a_q <= '0;
      delta_b_q <= '0;
    end else if (load_i) begin
      acc_a_q   <= base_a_i;
      acc_b_q   <= base_b_i;
      delta_a_q <= delta_a_i;
      delta_b_q <= delta_b_i;
    end else if (advance_i) begin
      acc_a_q <= acc_a_q + delta_a_q;
      acc_b_q <= acc_b_q + delta_b_q;
    end
  end

  assign acc_a_o = acc_a_q;
  assign acc_b_o = acc_b_q;

endmodule

// File: rtl/instr_dispatch.sv
// Pop side of the instruction queue. Each entry is expanded into
// copy_count copies sent to the arithmetic, RAM/DMA or load/store unit,
// with per-copy addresses base + k*delta. Outstanding DMAs are counted
// and drained on the program-end marker before program_complete pulses.
// Optional: DISPATCH_PERF_COUNTERS_EN enables perf_issued/perf_stall_cycles;
// otherwise both are tied to 0.
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   queue_empty, queue_re              show-ahead queue status, pop strobe
//   q_*                                head-of-queue entry fields
//   arith_valid/ready/instr            arithmetic unit channel
//   ram_valid/ready/instr/*_addr       RAM/DMA channel, ram_done completions
//   ldst_valid/ready/instr/cache_addr  load/store channel
//   program_complete                   one-cycle pulse after drain
//   dispatch_error                     sticky error flag
//   perf_issued, perf_stall_cycles     optional performance counters
module instr_dispatch
  import cherry_pkg::*;
#(
  parameter int unsigned LOG_SUPERSCALAR_WIDTH   = 3,
  parameter int unsigned LOG_MAX_OUTSTANDING_RAM = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           queue_empty,
  output logic                           queue_re,
  input  logic [1:0]                     q_instr_type,
  input  logic [LOG_SUPERSCALAR_WIDTH:0] q_copy_count,
  input  logic [ARITH_W-1:0]             q_arith_instr,
  input  logic [RAM_W-1:0]               q_ram_instr,
  input  logic [LDST_W-1:0]              q_ld_st_instr,
  input  logic [ADDR_W-1:0]              q_cache_addr,
  input  logic [ADDR_W-1:0]              q_main_mem_addr,
  input  logic [ADDR_W-1:0]              q_d_cache_addr,
  input  logic [ADDR_W-1:0]              q_d_main_mem_addr,
  output logic                           arith_valid,
  input  logic                           arith_ready,
  output logic [ARITH_W-1:0]             arith_instr,
  output logic                           ram_valid,
  input  logic                           ram_ready,
  output logic [RAM_W-1:0]               ram_instr,
  output logic [ADDR_W-1:0]              ram_cache_addr,
  output logic [ADDR_W-1:0]              ram_main_mem_addr,
  input  logic                           ram_done,
  output logic                           ldst_valid,
  input  logic                           ldst_ready,
  output logic [LDST_W-1:0]              ldst_instr,
  output logic [ADDR_W-1:0]              ldst_cache_addr,
  output logic                           program_complete,
  output logic                           dispatch_error,
  output logic [31:0]                    perf_issued,
  output logic [31:0]                    perf_stall_cycles
);

  localparam int unsigned CNT_W = LOG_SUPERSCALAR_WIDTH + 1;
  localparam int unsigned OUT_W = LOG_MAX_OUTSTANDING_RAM + 1;
  localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(1 << LOG_MAX_OUTSTANDING_RAM);

  dispatch_state_e   state_q, state_d;
  logic [1:0]        type_q, type_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  copy_idx_q, copy_idx_d;
  logic [ARITH_W-1:0] arith_q, arith_d;
  logic [RAM_W-1:0]  ram_q, ram_d;
  logic [LDST_W-1:0] ldst_q, ldst_d;
  logic [OUT_W-1:0]  outstanding_q, outstanding_d;
  logic              error_q, error_d;

  logic pop;
  logic advance;
  logic ram_blocked;
  logic ram_hs;
  logic zero_count_err;
  logic spurious_done;
  logic [ADDR_W-1:0] cur_cache, cur_mm;

  dispatch_addr_stepper u_stepper (
    .clk       (clk),
    .reset     (reset),
    .load_i    (pop),
    .advance_i (advance),
    .base_a_i  (q_cache_addr),
    .delta_a_i (q_d_cache_addr),
    .base_b_i  (q_main_mem_addr),
    .delta_b_i (q_d_main_mem_addr),
    .acc_a_o   (cur_cache),
    .acc_b_o   (cur_mm)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= DISP_FETCH;
      type_q        <= '0;
      count_q       <= '0;
      copy_idx_q    <= '0;
      arith_q       <= '0;
      ram_q         <= '0;
      ldst_q        <= '0;
      outstanding_q <= '0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      type_q        <= type_d;
      count_q       <= count_d;
      copy_idx_q    <= copy_idx_d;
      arith_q       <= arith_d;
      ram_q         <= ram_d;
      ldst_q        <= ldst_d;
      outstanding_q <= outstanding_d;
      error_q       <= error_d;
    end
  end

  // The pop decision is shared by FETCH and the last copy of ISSUE, so the
  // latch/next-state logic for a new entry sits after the case statement.
  always_comb begin
    state_d          = state_q;
    type_d           = type_q;
    count_d          = count_q;
    copy_idx_d       = copy_idx_q;
    arith_d          = arith_q;
    ram_d            = ram_q;
    ldst_d           = ldst_q;
    pop              = 1'b0;
    advance          = 1'b0;
    arith_valid      = 1'b0;
    ram_valid        = 1'b0;
    ldst_valid       = 1'b0;
    ram_blocked      = 1'b0;
    program_complete = 1'b0;
    zero_count_err   = 1'b0;
    if (!reset) begin
      case (state_q)
        DISP_FETCH: pop = !queue_empty;
        DISP_ISSUE: begin
          case (type_q)
            INSTR_TYPE_ARITHMETIC: arith_valid = 1'b1;
            INSTR_TYPE_RAM: begin
              ram_blocked = (outstanding_q == OUT_MAX);
              ram_valid   = !ram_blocked;
            end
            INSTR_TYPE_LOAD_STORE: ldst_valid = 1'b1;
            default: ;
          endcase
          advance = (arith_valid && arith_ready) || (ram_valid && ram_ready) ||
                    (ldst_valid && ldst_ready);
          if (advance) begin
            copy_idx_d = copy_idx_q + CNT_W'(1);
            if (copy_idx_q == count_q - CNT_W'(1)) begin
              if (!queue_empty) pop = 1'b1;
              else              state_d = DISP_FETCH;
            end
          end
        end
        DISP_DRAIN: begin
          if (outstanding_q == '0) begin
            program_complete = 1'b1;
            state_d          = DISP_FETCH;
          end
        end
        default: state_d = DISP_FETCH;
      endcase
    end
    if (pop) begin
      type_d     = q_instr_type;
      count_d    = q_copy_count;
      arith_d    = q_arith_instr;
      ram_d      = q_ram_instr;
      ldst_d     = q_ld_st_instr;
      copy_idx_d = '0;
      if (q_instr_type == INSTR_TYPE_PROG_END) begin
        state_d = DISP_DRAIN;
      end else if (q_copy_count == '0) begin
        zero_count_err = 1'b1;
        state_d        = DISP_FETCH;
      end else begin
        state_d = DISP_ISSUE;
      end
    end
  end

  assign queue_re = pop;
  assign ram_hs   = ram_valid && ram_ready;

  // A completion arriving with nothing in flight is an error; the counter
  // saturates at zero so stale completions after reset cannot underflow it.
  always_comb begin
    outstanding_d = outstanding_q;
    spurious_done = 1'b0;
    case ({ram_hs, ram_done})
      2'b10: outstanding_d = outstanding_q + OUT_W'(1);
      2'b01: begin
        if (outstanding_q == '0) spurious_done = 1'b1;
        else                     outstanding_d = outstanding_q - OUT_W'(1);
      end
      default: ;
    endcase
  end

  always_comb begin
    error_d = error_q || zero_count_err || spurious_done;
  end

  assign dispatch_error    = error_q;
  assign arith_instr       = arith_q;
  assign ram_instr         = ram_q;
  assign ram_cache_addr    = cur_cache;
  assign ram_main_mem_addr = cur_mm;
  assign ldst_instr        = ldst_q;
  assign ldst_cache_addr   = cur_cache;

`ifdef DISPATCH_PERF_COUNTERS_EN
  logic [31:0] perf_issued_q, perf_issued_d;
  logic [31:0] perf_stall_q, perf_stall_d;
  logic        stall;

  // Stalled handshakes and limit-withheld RAM copies are mutually exclusive.
  assign stall = (arith_valid && !arith_ready) || (ram_valid && !ram_ready) ||
                 (ldst_valid && !ldst_ready) || ram_blocked;

  always_comb begin
    perf_issued_d = perf_issued_q + 32'(advance);
    perf_stall_d  = perf_stall_q + 32'(stall);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_issued_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      perf_issued_q <= perf_issued_d;
      perf_stall_q  <= perf_stall_d;
    end
  end

  assign perf_issued       = perf_issued_q;
  assign perf_stall_cycles = perf_stall_q;
`else
  assign perf_issued       = '0;
  assign perf_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_instr_dispatch.sv
module tb_instr_dispatch;

  localparam logic [1:0] T_LDST  = 2'd0;
  localparam logic [1:0] T_RAM   = 2'd1;
  localparam logic [1:0] T_ARITH = 2'd2;
  localparam logic [1:0] T_END   = 2'd3;

`ifdef DISPATCH_PERF_COUNTERS_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  typedef struct packed {
    logic [1:0]  ty;
    logic [3:0]  cnt;
    logic [8:0]  arith;
    logic [2:0]  ram;
    logic [6:0]  ldst;
    logic [17:0] c;
    logic [17:0] dc;
    logic [17:0] mm;
    logic [17:0] dmm;
  } entry_t;

  typedef struct packed {
    logic [1:0]  ty;
    logic [8:0]  instr;
    logic [17:0] cache;
    logic [17:0] mm;
  } copy_t;

  logic        clk, reset, queue_empty, queue_re;
  logic [1:0]  q_instr_type;
  logic [3:0]  q_copy_count;
  logic [8:0]  q_arith_instr;
  logic [2:0]  q_ram_instr;
  logic [6:0]  q_ld_st_instr;
  logic [17:0] q_cache_addr, q_main_mem_addr, q_d_cache_addr, q_d_main_mem_addr;
  logic        arith_valid, arith_ready, ram_valid, ram_ready, ram_done;
  logic        ldst_valid, ldst_ready, program_complete, dispatch_error;
  logic [8:0]  arith_instr;
  logic [2:0]  ram_instr;
  logic [6:0]  ldst_instr;
  logic [17:0] ram_cache_addr, ram_main_mem_addr, ldst_cache_addr;
  logic [31:0] perf_issued, perf_stall_cycles;

  instr_dispatch #(
    .LOG_SUPERSCALAR_WIDTH   (3),
    .LOG_MAX_OUTSTANDING_RAM (2)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .queue_empty       (queue_empty),
    .queue_re          (queue_re),
    .q_instr_type      (q_instr_type),
    .q_copy_count      (q_copy_count),
    .q_arith_instr     (q_arith_instr),
    .q_ram_instr       (q_ram_instr),
    .q_ld_st_instr     (q_ld_st_instr),
    .q_cache_addr      (q_cache_addr),
    .q_main_mem_addr   (q_main_mem_addr),
    .q_d_cache_addr    (q_d_cache_addr),
    .q_d_main_mem_addr (q_d_main_mem_addr),
    .arith_valid       (arith_valid),
    .arith_ready       (arith_ready),
    .arith_instr       (arith_instr),
    .ram_valid         (ram_valid),
    .ram_ready         (ram_ready),
    .ram_instr         (ram_instr),
    .ram_cache_addr    (ram_cache_addr),
    .ram_main_mem_addr (ram_main_mem_addr),
    .ram_done          (ram_done),
    .ldst_valid        (ldst_valid),
    .ldst_ready        (ldst_ready),
    .ldst_instr        (ldst_instr),
    .ldst_cache_addr   (ldst_cache_addr),
    .program_complete  (program_complete),
    .dispatch_error    (dispatch_error),
    .perf_issued       (perf_issued),
    .perf_stall_cycles (perf_stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  entry_t src[$];
  copy_t  exp_q[$];
  copy_t  obs_q[$];
  int     tests_run = 0;
  int     tests_failed = 0;
  int     out_m = 0;
  logic   hold_empty = 1'b0;

  logic        s_qre, s_av, s_rv, s_lv, s_ar, s_rr, s_lr, s_done, s_pc, s_err;
  logic [8:0]  s_ai;
  logic [2:0]  s_ri;
  logic [6:0]  s_li;
  logic [17:0] s_rc, s_rm, s_lc;
  logic [31:0] s_pi, s_ps;

  task automatic drive_q();
    queue_empty = hold_empty || (src.size() == 0);
    if (src.size() > 0) begin
      q_instr_type      = src[0].ty;
      q_copy_count      = src[0].cnt;
      q_arith_instr     = src[0].arith;
      q_ram_instr       = src[0].ram;
      q_ld_st_instr     = src[0].ldst;
      q_cache_addr      = src[0].c;
      q_d_cache_addr    = src[0].dc;
      q_main_mem_addr   = src[0].mm;
      q_d_main_mem_addr = src[0].dmm;
    end else begin
      q_instr_type = '0; q_copy_count = '0; q_arith_instr = '0; q_ram_instr = '0;
      q_ld_st_instr = '0; q_cache_addr = '0; q_d_cache_addr = '0;
      q_main_mem_addr = '0; q_d_main_mem_addr = '0;
    end
  endtask

  function automatic entry_t mk(logic [1:0] ty, int unsigned cnt, int unsigned c,
                                int unsigned dc, int unsigned mm, int unsigned dmm);
    entry_t e;
    e.ty = ty; e.cnt = 4'(cnt);
    e.arith = 9'($urandom); e.ram = 3'($urandom); e.ldst = 7'($urandom);
    e.c = 18'(c); e.dc = 18'(dc); e.mm = 18'(mm); e.dmm = 18'(dmm);
    return e;
  endfunction

  // Queue the entry and append the copies it should expand into.
  task automatic push_entry(input entry_t e);
    src.push_back(e);
    if (e.ty != T_END) begin
      for (int unsigned k = 0; k < e.cnt; k++) begin
        copy_t x;
        x = '0;
        x.ty = e.ty;
        if (e.ty == T_ARITH) x.instr = e.arith;
        else if (e.ty == T_RAM) begin
          x.instr = 9'(e.ram);
          x.cache = 18'(int'(e.c) + k * int'(e.dc));
          x.mm    = 18'(int'(e.mm) + k * int'(e.dmm));
        end else begin
          x.instr = 9'(e.ldst);
          x.cache = 18'(int'(e.c) + k * int'(e.dc));
        end
        exp_q.push_back(x);
      end
    end
    drive_q();
  endtask

  task automatic tick();
    @(negedge clk);
    s_qre = queue_re; s_av = arith_valid; s_rv = ram_valid; s_lv = ldst_valid;
    s_ar = arith_ready; s_rr = ram_ready; s_lr = ldst_ready; s_done = ram_done;
    s_pc = program_complete; s_err = dispatch_error;
    s_ai = arith_instr; s_ri = ram_instr; s_li = ldst_instr;
    s_rc = ram_cache_addr; s_rm = ram_main_mem_addr; s_lc = ldst_cache_addr;
    s_pi = perf_issued; s_ps = perf_stall_cycles;
    if (s_av && s_ar) obs_q.push_back({T_ARITH, s_ai, 18'd0, 18'd0});
    if (s_rv && s_rr) obs_q.push_back({T_RAM, 9'(s_ri), s_rc, s_rm});
    if (s_lv && s_lr) obs_q.push_back({T_LDST, 9'(s_li), s_lc, 18'd0});
    if (!reset) begin
      if ((s_rv && s_rr) && !s_done) out_m++;
      else if (s_done && !(s_rv && s_rr) && out_m > 0) out_m--;
    end
    @(posedge clk);
    #1;
    if (s_qre && src.size() > 0) void'(src.pop_front());
    ram_done = 1'b0;
    drive_q();
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    src.delete(); exp_q.delete(); obs_q.delete();
    hold_empty = 1'b0;
    arith_ready = 1'b0; ram_ready = 1'b0; ldst_ready = 1'b0; ram_done = 1'b0;
    drive_q();
    tick();
    tick();
    reset = 1'b0;
    out_m = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    tick();
    tests_run++;
    if ({s_qre, s_av, s_rv, s_lv, s_pc, s_err} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %b expected 000000", {s_qre, s_av, s_rv, s_lv, s_pc, s_err});
    end
    tests_run++;
    if ({s_rc, s_rm, s_lc} !== 54'd0) begin
      tests_failed++;
      $display("FAIL reset_addr: got %h/%h/%h expected 0", s_rc, s_rm, s_lc);
    end
    tests_run++;
    if ({s_ai, s_ri, s_li} !== 19'd0) begin
      tests_failed++;
      $display("FAIL reset_instr: got %h/%h/%h expected 0", s_ai, s_ri, s_li);
    end
    tests_run++;
    if ({s_pi, s_ps} !== 64'd0) begin
      tests_failed++;
      $display("FAIL reset_perf: got %0d/%0d expected 0", s_pi, s_ps);
    end
  endtask

  task automatic test_arith_burst();
    int qre_n = 0, av_n = 0, first = -1, last = -1;
    exp_q.delete(); obs_q.delete();
    arith_ready = 1'b1;
    push_entry(mk(T_ARITH, 3, 0, 0, 0, 0));
    for (int i = 0; i < 8; i++) begin
      tick();
      if (s_qre) qre_n++;
      if (s_av) begin
        av_n++;
        if (first < 0) first = i;
        last = i;
      end
    end
    tests_run++;
    if (qre_n != 1) begin
      tests_failed++; $display("FAIL arith_pops: got %0d expected 1", qre_n);
    end
    tests_run++;
    if (av_n != 3 || last - first != 2) begin
      tests_failed++;
      $display("FAIL arith_valid_run: got %0d cycles span %0d expected 3 span 2", av_n, last - first);
    end
    tests_run++;
    if (obs_q.size() != 3 || obs_q[0] !== exp_q[0] || obs_q[2] !== exp_q[2]) begin
      tests_failed++;
      $display("FAIL arith_data: got %0d copies expected 3 with instr %h", obs_q.size(), exp_q[0].instr);
    end
    arith_ready = 1'b0;
  endtask

  task automatic test_ram_wrap();
    logic [17:0] ec[3];
    logic [17:0] em[3];
    ec = '{18'd100, 18'd105, 18'd110};
    em = '{18'h3FFFE, 18'h00001, 18'h00004};
    exp_q.delete(); obs_q.delete();
    ram_ready = 1'b1;
    push_entry(mk(T_RAM, 3, 100, 5, 'h3FFFE, 3));
    for (int i = 0; i < 6; i++) tick();
    tests_run++;
    if (obs_q.size() != 3) begin
      tests_failed++; $display("FAIL ram_wrap_count: got %0d expected 3", obs_q.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        tests_run++;
        if (obs_q[k].cache !== ec[k] || obs_q[k].mm !== em[k]) begin
          tests_failed++;
          $display("FAIL ram_wrap_addr%0d: got %h/%h expected %h/%h", k, obs_q[k].cache, obs_q[k].mm, ec[k], em[k]);
        end
      end
    end
    ram_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ram_done = 1'b1;
      tick();
    end
  endtask

  task automatic test_ram_limit();
    int hs = 0;
    exp_q.delete(); obs_q.delete();
    ram_ready = 1'b1;
    push_entry(mk(T_RAM, 5, $urandom_range(0, 'h3FFFF), 7, 9, 'h20000));
    for (int i = 0; i < 12; i++) begin
      tick();
      if (s_rv && s_rr) hs++;
    end
    tests_run++;
    if (hs != 4 || s_rv !== 1'b0) begin
      tests_failed++;
      $display("FAIL ram_limit_hold: got %0d handshakes valid=%b expected 4 valid=0", hs, s_rv);
    end
    ram_done = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      if (s_rv && s_rr) hs++;
    end
    tests_run++;
    if (hs != 5) begin
      tests_failed++; $display("FAIL ram_limit_release: got %0d handshakes expected 5", hs);
    end
    for (int k = 0; k < exp_q.size(); k++) begin
      tests_run++;
      if (k >= obs_q.size() || obs_q[k] !== exp_q[k]) begin
        tests_failed++;
        $display("FAIL ram_limit_copy%0d: got %h expected %h", k, (k < obs_q.size()) ? obs_q[k] : '0, exp_q[k]);
      end
    end
    ram_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ram_done = 1'b1;
      tick();
    end
  endtask

  task automatic test_ldst_stall();
    logic [31:0] pi0, ps0;
    exp_q.delete(); obs_q.delete();
    ldst_ready = 1'b0;
    push_entry(mk(T_LDST, 2, $urandom_range(0, 'h3FFFF), $urandom_range(0, 'h3FFFF), 0, 0));
    tick();
    pi0 = s_pi; ps0 = s_ps;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if ({s_lv, s_li, s_lc} !== {1'b1, exp_q[0].instr[6:0], exp_q[0].cache}) begin
        tests_failed++;
        $display("FAIL ldst_hold%0d: got v=%b %h/%h expected v=1 %h/%h", i, s_lv, s_li, s_lc, exp_q[0].instr[6:0], exp_q[0].cache);
      end
    end
    ldst_ready = 1'b1;
    tick();
    tick();
    tick();
    tests_run++;
    if (obs_q.size() != 2 || obs_q[1] !== exp_q[1]) begin
      tests_failed++;
      $display("FAIL ldst_copies: got %0d copies expected 2, second cache %h", obs_q.size(), exp_q[1].cache);
    end
    tests_run++;
    if ((s_ps - ps0) !== (PERF_EN ? 32'd3 : 32'd0)) begin
      tests_failed++; $display("FAIL ldst_perf_stall: got %0d expected %0d", s_ps - ps0, PERF_EN ? 3 : 0);
    end
    tests_run++;
    if ((s_pi - pi0) !== (PERF_EN ? 32'd2 : 32'd0)) begin
      tests_failed++; $display("FAIL ldst_perf_issued: got %0d expected %0d", s_pi - pi0, PERF_EN ? 2 : 0);
    end
    ldst_ready = 1'b0;
  endtask

  task automatic test_drain();
    int pc_n = 0, pc_at = -1, qre_drain = 0;
    logic qre13 = 1'b0;
    exp_q.delete(); obs_q.delete();
    ram_ready = 1'b1; arith_ready = 1'b1;
    push_entry(mk(T_RAM, 1, 40, 1, 80, 1));
    push_entry(mk(T_END, 0, 0, 0, 0, 0));
    push_entry(mk(T_ARITH, 1, 0, 0, 0, 0));
    for (int i = 0; i < 16; i++) begin
      if (i == 11) ram_done = 1'b1;
      tick();
      if (s_pc) begin pc_n++; pc_at = i; end
      if (i >= 2 && i <= 12 && s_qre) qre_drain++;
      if (i == 13) qre13 = s_qre;
    end
    tests_run++;
    if (pc_n != 1 || pc_at != 12) begin
      tests_failed++; $display("FAIL drain_complete: got %0d pulses at %0d expected 1 at 12", pc_n, pc_at);
    end
    tests_run++;
    if (qre_drain != 0 || qre13 !== 1'b1) begin
      tests_failed++;
      $display("FAIL drain_no_pop: got %0d pops in drain, resume pop %b expected 0 and 1", qre_drain, qre13);
    end
    tests_run++;
    if (obs_q.size() != 2 || obs_q[0] !== exp_q[0] || obs_q[1] !== exp_q[1]) begin
      tests_failed++; $display("FAIL drain_copies: got %0d copies expected 2", obs_q.size());
    end
    ram_ready = 1'b0; arith_ready = 1'b0;
  endtask

  task automatic test_zero_count();
    exp_q.delete(); obs_q.delete();
    ldst_ready = 1'b1; arith_ready = 1'b1;
    push_entry(mk(T_ARITH, 0, 0, 0, 0, 0));
    push_entry(mk(T_LDST, 1, 777, 3, 0, 0));
    tick();
    tests_run++;
    if ({s_qre, s_err} !== 2'b10) begin
      tests_failed++; $display("FAIL zero_pop: got re=%b err=%b expected re=1 err=0", s_qre, s_err);
    end
    tick();
    tests_run++;
    if ({s_err, s_av, s_rv, s_lv, s_qre} !== 5'b10001) begin
      tests_failed++;
      $display("FAIL zero_error: got err/av/rv/lv/re=%b expected 10001", {s_err, s_av, s_rv, s_lv, s_qre});
    end
    tick();
    tick();
    tests_run++;
    if (obs_q.size() != 1 || obs_q[0] !== exp_q[0] || s_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL zero_next_entry: got %0d copies err=%b expected 1 copy err=1", obs_q.size(), s_err);
    end
    ldst_ready = 1'b0; arith_ready = 1'b0;
  endtask

  task automatic test_reset_midtransfer();
    int qre_n = 0;
    exp_q.delete(); obs_q.delete();
    push_entry(mk(T_ARITH, 4, 0, 0, 0, 0));
    tick(); tick(); tick();
    tests_run++;
    if (s_av !== 1'b1) begin
      tests_failed++; $display("FAIL midreset_pre: got av=%b expected 1", s_av);
    end
    apply_reset();
    tick();
    tests_run++;
    if ({s_qre, s_av, s_rv, s_lv, s_err, s_ai} !== 14'd0) begin
      tests_failed++;
      $display("FAIL midreset_post: got %b/%h expected all 0", {s_qre, s_av, s_rv, s_lv, s_err}, s_ai);
    end
    ldst_ready = 1'b1;
    push_entry(mk(T_LDST, 1, 12, 0, 0, 0));
    for (int i = 0; i < 3; i++) begin
      tick();
      if (s_qre) qre_n++;
    end
    tests_run++;
    if (qre_n != 1 || obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
      tests_failed++;
      $display("FAIL midreset_resume: got %0d pops %0d copies expected 1 and 1", qre_n, obs_q.size());
    end
    ldst_ready = 1'b0;
  endtask

  task automatic test_random();
    int budget = 0;
    int om;
    logic [31:0] pi0;
    logic        p_stall = 1'b0;
    logic [2:0]  p_v;
    logic [78:0] p_data;
    apply_reset();
    tick();
    pi0 = s_pi;
    for (int n = 0; n < 40; n++)
      push_entry(mk(2'($urandom_range(0, 2)), $urandom_range(1, 8), $urandom, $urandom,
                    $urandom, $urandom));
    while (!(src.size() == 0 && obs_q.size() == exp_q.size()) && budget < 5000) begin
      arith_ready = ($urandom_range(0, 3) != 0);
      ram_ready   = ($urandom_range(0, 3) != 0);
      ldst_ready  = ($urandom_range(0, 3) != 0);
      ram_done    = (out_m > 0) && ($urandom_range(0, 2) == 0);
      hold_empty  = ($urandom_range(0, 3) == 0);
      drive_q();
      om = out_m;
      tick();
      budget++;
      if ($countones({s_av, s_rv, s_lv}) > 1) begin
        tests_run++; tests_failed++;
        $display("FAIL rand_onehot: got av/rv/lv=%b at cycle %0d", {s_av, s_rv, s_lv}, budget);
      end
      if (om >= 4) begin
        tests_run++;
        if (s_rv !== 1'b0) begin
          tests_failed++; $display("FAIL rand_ram_limit: got rv=1 with %0d outstanding", om);
        end
      end
      if (p_stall) begin
        tests_run++;
        if ({s_av, s_rv, s_lv} !== p_v || {s_ai, s_ri, s_rc, s_rm, s_li, s_lc} !== p_data) begin
          tests_failed++; $display("FAIL rand_stable: valid/data changed while stalled at cycle %0d", budget);
        end
      end
      p_stall = (s_av && !s_ar) || (s_rv && !s_rr) || (s_lv && !s_lr);
      p_v     = {s_av, s_rv, s_lv};
      p_data  = {s_ai, s_ri, s_rc, s_rm, s_li, s_lc};
    end
    hold_empty = 1'b0;
    drive_q();
    if (budget >= 5000) begin
      tests_run++; tests_failed++;
      $display("FAIL rand_timeout: got %0d copies expected %0d", obs_q.size(), exp_q.size());
    end
    tests_run++;
    if (obs_q.size() != exp_q.size()) begin
      tests_failed++; $display("FAIL rand_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
      tests_run++;
      if (obs_q[k] !== exp_q[k]) begin
        tests_failed++; $display("FAIL rand_copy%0d: got %h expected %h", k, obs_q[k], exp_q[k]);
      end
    end
    arith_ready = 1'b0; ram_ready = 1'b0; ldst_ready = 1'b0;
    tick();
    tests_run++;
    if ((s_pi - pi0) !== (PERF_EN ? 32'(exp_q.size()) : 32'd0)) begin
      tests_failed++;
      $display("FAIL rand_perf_issued: got %0d expected %0d", s_pi - pi0, PERF_EN ? exp_q.size() : 0);
    end
    for (int i = 0; i < 8 && out_m > 0; i++) begin
      ram_done = 1'b1;
      tick();
    end
    tick();
    tests_run++;
    if (s_err !== 1'b0) begin
      tests_failed++; $display("FAIL rand_error: got %b expected 0", s_err);
    end
  endtask

  initial begin
    reset = 1'b1;
    arith_ready = 1'b0; ram_ready = 1'b0; ldst_ready = 1'b0; ram_done = 1'b0;
    drive_q();
    test_reset();
    test_arith_burst();
    test_ram_wrap();
    test_ram_limit();
    test_ldst_stall();
    test_drain();
    test_zero_count();
    test_reset_midtransfer();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
